// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM encoding, default tick
// divider, seven-segment constants and BCD helper functions.
package countdown_pkg;

    // 50 MHz / 500000 = one tick every 0.01 s
    localparam int TICK_DIV_DEFAULT = 500000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PAUSED = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Force every nibble into the legal BCD range 0..9
    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Subtract one with decimal borrow; saturates at 0000
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        if (v == 16'h0000) return 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Non-decimal codes light nothing.
module seg7_decode
    import countdown_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_timer.sv
// Four-digit BCD countdown timer (tens of seconds down to hundredths) with
// preset load, start/pause toggle and registered seven-segment outputs.
//
// Control protocol: load is a level sampled every cycle and always wins;
// start_stop is a debounced level whose rising edge (detected against a
// one-cycle delayed copy) toggles RUN/PAUSED. An edge coinciding with load
// is dropped, not deferred.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic        RST,
    input  logic        load,
    input  logic [15:0] preset_bcd,
    input  logic        start_stop,
    output logic [15:0] digits,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        running,
    output logic        done,
    output state_t      dbg_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t      state;
    logic [PW-1:0] prescaler;
    logic        start_stop_q;
    logic        start_edge;
    logic [15:0] preset_clamped;
    logic [6:0]  seg0_next, seg1_next, seg2_next, seg3_next;

    assign start_edge     = start_stop & ~start_stop_q;
    assign preset_clamped = bcd_clamp(preset_bcd);

    assign running   = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    // Main FSM: load, run/pause toggling, prescaler and BCD decrement
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state        <= ST_IDLE;
            digits       <= 16'h0000;
            prescaler    <= '0;
            start_stop_q <= 1'b0;
        end else begin
            start_stop_q <= start_stop;
            if (load) begin
                digits <= preset_clamped;
                state  <= (preset_clamped == 16'h0000) ? ST_IDLE : ST_PAUSED;
            end else begin
                case (state)
                    ST_PAUSED: begin
                        if (start_edge) begin
                            state     <= ST_RUN;
                            prescaler <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (start_edge) begin
                            // Pausing takes precedence over a coincident tick
                            state <= ST_PAUSED;
                        end else if (prescaler == PRESC_LAST) begin
                            prescaler <= '0;
                            digits    <= bcd_dec(digits);
                            if (digits <= 16'h0001) state <= ST_DONE;
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                    default: ; // IDLE and DONE hold everything
                endcase
            end
        end
    end

    seg7_decode u_seg0 (.bcd(digits[3:0]),   .seg(seg0_next));
    seg7_decode u_seg1 (.bcd(digits[7:4]),   .seg(seg1_next));
    seg7_decode u_seg2 (.bcd(digits[11:8]),  .seg(seg2_next));
    seg7_decode u_seg3 (.bcd(digits[15:12]), .seg(seg3_next));

    // Display registers: one cycle behind digits, show "0000" out of reset
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            HEX0 <= SEG_0;
            HEX1 <= SEG_0;
            HEX2 <= SEG_0;
            HEX3 <= SEG_0;
        end else begin
            HEX0 <= seg0_next;
            HEX1 <= seg1_next;
            HEX2 <= seg2_next;
            HEX3 <= seg3_next;
        end
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: TICK_DIV, default 500000, CLOCK_50 cycles per 0.01 s tick.
REQ-002 CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-003 RST  in  1  reset; synchronous and active-high.
REQ-004 load  in  1  level; when high, capture preset_bcd this cycle.
REQ-005 preset_bcd  in  16  BCD start value, nibbles [15:12] tens-s, [11:8] s, [7:4] tenths, [3:0] hundredths.
REQ-006 start_stop  in  1  debounced level; each rising edge toggles run/pause.
REQ-007 digits  out  16  current BCD value, same nibble order as preset_bcd.
REQ-008 HEX0..HEX3  out  7 each  active-low segments for digits[3:0]..digits[15:12].
REQ-009 running  out  1  high in state RUN.
REQ-010 done  out  1  high in state DONE.

Function
REQ-011 States SHALL be IDLE, PAUSED, RUN and DONE; running and done SHALL be decoded from the registered state.
REQ-012 Start edge SHALL be start_stop & ~start_stop_q, where start_stop_q is start_stop registered one cycle.
REQ-013 load SHALL have priority over a start edge in the same cycle; that start edge SHALL be discarded.
REQ-014 On load, each preset nibble above 9 SHALL be clamped to 9 before it is stored in digits.
REQ-015 On load, the next state SHALL be IDLE if the clamped value is 0000, otherwise PAUSED.
REQ-016 load SHALL be accepted in all four states.
REQ-017 In PAUSED, a start edge SHALL move the block to RUN and clear the prescaler.
REQ-018 In IDLE and DONE, start edges SHALL be ignored.
REQ-019 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; the tick SHALL be the cycle on which it wraps.
REQ-020 The first decrement SHALL occur exactly TICK_DIV cycles after the start-edge cycle.
REQ-021 Each tick SHALL decrement digits by 1 using BCD borrow: a digit at 0 becomes 9 and borrows from the next digit up.
REQ-022 When a tick decrements digits to 0000, the next state SHALL be DONE; digits SHALL never wrap below 0000.
REQ-023 In RUN, a start edge SHALL move the block to PAUSED; a tick in the same cycle SHALL be suppressed.
REQ-024 In PAUSED, IDLE and DONE, the prescaler and digits SHALL hold their values.
REQ-025 The HEX outputs SHALL be registered and SHALL lag digits by one cycle.
REQ-026 Segment encoding (active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-027 A nibble value above 9 SHALL display as 1111111 (blank).

Reset
REQ-028 While RST is high at a clock edge: state becomes IDLE, digits 0000, prescaler 0, start_stop_q 0, running 0, done 0.
REQ-029 While RST is high at a clock edge, HEX0..HEX3 SHALL become 1000000.
REQ-030 RST SHALL override load, start edges and ticks in the same cycle.
REQ-031 RST asserted mid-run SHALL abort the countdown with no residual tick.

Structure
REQ-032 Package countdown_pkg SHALL hold the state encoding, the TICK_DIV default and the ten segment constants.
REQ-033 A sub-module seg7_decode (4-bit BCD in, 7-bit active-low out, combinational) SHALL be instantiated four times.
REQ-034 The HEX output registers SHALL be in the top level.

Verification (TICK_DIV=4)
REQ-035 Reset: RST high for 2 cycles -> digits 0000, all HEX 1000000, running 0, done 0.
REQ-036 Countdown: load 0x0012, then start edge at cycle T -> 0011 at T+4, 0010 at T+8, 0000 and done=1 at T+48.
REQ-037 Borrow: load 0x1000, run 1 tick -> digits 0x0999, HEX2 0010000, HEX3 1000000.
REQ-038 Pause: load 0x0050, run 2 ticks (0048), start edge then hold 20 cycles -> digits stay 0048.
REQ-039 Resume: second start edge at cycle R -> digits 0047 at R+4.
REQ-040 Priority/clamp: load 0x1A2F and a start edge in the same cycle -> digits 0x1929, state PAUSED, running 0.
REQ-041 Mid-run reset: RST mid-RUN -> IDLE, digits 0000, no decrement afterwards.
